frog_sprite_renderer: RTL

Per-pixel sprite fetch engine that produces the 2-bit palette index consumed by the colour picker. It sits between the VGA timing generator and `color_picker`. For every active pixel tick it decides whether the beam is inside the frog sprite's screen rectangle, reads the matching texel from an internal 2bpp sprite ROM with integer upscaling, and outputs the index and a hit flag. Output is delayed by a fixed pipeline latency.

---
 rtl/frog_pkg.sv | 30 +++
 rtl/sprite_rom.sv | 29 ++
 rtl/frog_sprite_renderer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/frog_pkg.sv
// Shared constants for the frog sprite path: screen size, transparent palette index
// and the 16x16 2bpp frog ROM (column 0 is the MSB texel pair of each row).
package frog_pkg;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam logic [1:0] TRANSPARENT_IDX_DEF = 2'b11;

    localparam int FROG_W = 16;
    localparam int FROG_H = 16;

    localparam logic [2*FROG_W-1:0] FROG_ROM [FROG_H] = '{
        32'h5F0F_F0F6,
        32'h7D55_57D9,
        32'h9AA5_5AA6,
        32'hD5A5_A5A7,
        32'h1654_9E3B,
        32'h4D7C_2E81,
        32'hB0C3_F5A9,
        32'hE1D2_C3B4,
        32'h0F1E_2D3C,
        32'hA5B4_C3D2,
        32'h3C4B_5A69,
        32'hF00F_F00F,
        32'h6789_ABCD,
        32'h1234_FEDC,
        32'hC0FF_EE11,
        32'h8E5A_3C72
    };
endpackage

// File: rtl/sprite_rom.sv
// Row-addressed frog ROM with a registered read port; the register is the
// second pipeline stage's fetch and only advances when en is high.
module sprite_rom
    import frog_pkg::*;
#(
    parameter int SPRITE_W = 16,
    parameter int SPRITE_H = 16,
    parameter int ROW_W    = $clog2(SPRITE_H)
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [ROW_W-1:0]      row,
    output logic [2*SPRITE_W-1:0] data_q
);

    logic [2*SPRITE_W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (en) begin
            data_d = FROG_ROM[row];
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

endmodule

// File: rtl/frog_sprite_renderer.sv
// Two-stage frog sprite fetch: box test and texel address, then ROM fetch and texel select.
// Define FROG_SPRITE_MIRROR_EN to add the mirror_x input (horizontal flip latched per frame).
module frog_sprite_renderer
    import frog_pkg::*;
#(
    parameter int         SPRITE_W        = 16,
    parameter int         SPRITE_H        = 16,
    parameter int         SCALE           = 2,
    parameter int         COORD_W         = 10,
    parameter logic [1:0] TRANSPARENT_IDX = TRANSPARENT_IDX_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start,
    input  logic               pix_en,
    input  logic [COORD_W-1:0] hcount,
    input  logic [COORD_W-1:0] vcount,
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] pos_y,
`ifdef FROG_SPRITE_MIRROR_EN
    input  logic               mirror_x,
`endif
    output logic [1:0]         sprite_pixel,
    output logic               sprite_hit
);

    localparam int SHIFT = $clog2(SCALE);
    localparam int COL_W = $clog2(SPRITE_W);
    localparam int ROW_W = $clog2(SPRITE_H);
    localparam logic [COORD_W-1:0] BOX_W = COORD_W'(SPRITE_W * SCALE);
    localparam logic [COORD_W-1:0] BOX_H = COORD_W'(SPRITE_H * SCALE);

    logic [COORD_W-1:0] x_l_q, x_l_d;
    logic [COORD_W-1:0] y_l_q, y_l_d;
    logic               mirror_l;

    logic [COORD_W:0]   dx, dy;
    logic [COL_W-1:0]   col_raw;

    logic               inside_p1_q, inside_p1_d;
    logic [ROW_W-1:0]   row_p1_q, row_p1_d;
    logic [COL_W-1:0]   col_p1_q, col_p1_d;

    logic               inside_p2_q, inside_p2_d;
    logic [COL_W-1:0]   col_p2_q, col_p2_d;
    logic [2*SPRITE_W-1:0] rom_word_p2_q;
    logic [COL_W-1:0]   col_rev_p2;
    logic [1:0]         texel_p2;

    // Position latch: only frame_start moves it, so stage 1 in the same cycle sees the old value.
    always_comb begin
        x_l_d = x_l_q;
        y_l_d = y_l_q;
        if (frame_start) begin
            x_l_d = pos_x;
            y_l_d = pos_y;
        end
    end

`ifdef FROG_SPRITE_MIRROR_EN
    logic mirror_l_q, mirror_l_d;

    always_comb begin
        mirror_l_d = mirror_l_q;
        if (frame_start) begin
            mirror_l_d = mirror_x;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mirror_l_q <= 1'b0;
        end else begin
            mirror_l_q <= mirror_l_d;
        end
    end

    assign mirror_l = mirror_l_q;
`else
    assign mirror_l = 1'b0;
`endif

    // Stage 1: the extra top bit of each difference is the borrow, so a beam left of or
    // above the sprite never wraps into the box.
    always_comb begin
        dx = {1'b0, hcount} - {1'b0, x_l_q};
        dy = {1'b0, vcount} - {1'b0, y_l_q};
        col_raw = dx[SHIFT +: COL_W];

        inside_p1_d = inside_p1_q;
        row_p1_d    = row_p1_q;
        col_p1_d    = col_p1_q;
        if (pix_en) begin
            inside_p1_d = !dx[COORD_W] && !dy[COORD_W]
                          && (dx[COORD_W-1:0] < BOX_W) && (dy[COORD_W-1:0] < BOX_H);
            row_p1_d    = dy[SHIFT +: ROW_W];
            // SPRITE_W is a power of two, so SPRITE_W-1-col is the bitwise complement.
            col_p1_d    = mirror_l ? ~col_raw : col_raw;
        end
    end

    // Stage 2: ROM word fetch alongside the delayed column and inside flag.
    always_comb begin
        inside_p2_d = inside_p2_q;
        col_p2_d    = col_p2_q;
        if (pix_en) begin
            inside_p2_d = inside_p1_q;
            col_p2_d    = col_p1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_l_q       <= '0;
            y_l_q       <= '0;
            inside_p1_q <= 1'b0;
            inside_p2_q <= 1'b0;
        end else begin
            x_l_q       <= x_l_d;
            y_l_q       <= y_l_d;
            inside_p1_q <= inside_p1_d;
            inside_p2_q <= inside_p2_d;
        end
    end

    always_ff @(posedge clk) begin
        row_p1_q <= row_p1_d;
        col_p1_q <= col_p1_d;
        col_p2_q <= col_p2_d;
    end

    sprite_rom #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H),
        .ROW_W    (ROW_W)
    ) u_rom (
        .clk    (clk),
        .en     (pix_en),
        .row    (row_p1_q),
        .data_q (rom_word_p2_q)
    );

    // Column 0 is the MSB pair, so the pair index is the complemented column.
    always_comb begin
        col_rev_p2 = ~col_p2_q;
        texel_p2   = rom_word_p2_q[{col_rev_p2, 1'b0} +: 2];
        sprite_pixel = TRANSPARENT_IDX;
        sprite_hit   = 1'b0;
        if (inside_p2_q) begin
            sprite_pixel = texel_p2;
            sprite_hit   = (texel_p2 != TRANSPARENT_IDX);
        end
    end

endmodule
